// File: rtl/skeleton_pkg.sv
// Shared types for the waveform LUT capture stage: sequencer states and
// header length.
package skeleton_pkg;

    typedef enum logic [2:0] {
        IDLE,
        WAIT,
        PULSE,
        CAPT,
        HEAD,
        DATA,
        DONE
    } state_t;

    localparam int HEAD_WORDS = 2;

endpackage

// File: rtl/skeleton_sync_fifo.sv
// Single-clock capture FIFO. pop_data is the oldest entry, read straight
// from the storage flops, so a pop consumes the word already on pop_data.
module skeleton_sync_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 256,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = AW + 1
) (
    input  logic             CLK_SYS,
    input  logic             nRST,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty,
    output logic [CW-1:0]    count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CW-1:0]    count_q;
    logic             do_push;
    logic             do_pop;

    assign full     = (count_q == CW'(DEPTH));
    assign empty    = (count_q == '0);
    assign count    = count_q;
    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;
    assign pop_data = mem[rd_ptr];

    // Storage is not reset; the pointers alone define what is valid.
    always_ff @(posedge CLK_SYS) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge CLK_SYS or negedge nRST) begin
        if (!nRST) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/skeleton_wvf_capture.sv
// Capture stage for the waveform LUT skeleton: paces the LUT with trigger
// pulses, buffers returned samples, then streams header + samples to the host.
module skeleton_wvf_capture
    import skeleton_pkg::*;
#(
    parameter int BITWIDTH_SYS  = 16,
    parameter int BITWIDTH_HEAD = 32,
    parameter int FIFO_DEPTH    = 256,
    parameter int DIV_WIDTH     = 16,
    parameter int CAPT_DELAY    = 1,
    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1
) (
    input  logic                     CLK_SYS,
    input  logic                     nRST,
    input  logic                     EN,
    input  logic                     START,
    input  logic [DIV_WIDTH-1:0]     TRG_DIV,
    output logic                     TRGG_START_CALC,
    input  logic [BITWIDTH_SYS-1:0]  DUT_DATA,
    input  logic                     DUT_RDY,
    input  logic [BITWIDTH_HEAD-7:0] DUT_HEAD,
    output logic [BITWIDTH_SYS-1:0]  M_DATA,
    output logic                     M_VALID,
    input  logic                     M_READY,
    output logic                     M_LAST,
    output logic                     BUSY,
    output logic                     OVERFLOW,
    output logic [CNT_W-1:0]         SAMPLE_CNT,
    output logic [2:0]               dbg_state
);

    state_t                   state_q, state_d;
    logic [DIV_WIDTH-1:0]     div_q, div_d;
    logic [DIV_WIDTH-1:0]     div_end;
    logic                     hidx_q, hidx_d;
    logic [31:0]              head_q;
    logic [BITWIDTH_SYS-1:0]  m_data_q;
    logic                     m_valid_q;
    logic                     m_last_q;
    logic                     overflow_q;
    logic [CNT_W-1:0]         sample_cnt_q;

    logic                     push, pop, load, load_last;
    logic [BITWIDTH_SYS-1:0]  load_data;
    logic                     start_acc, set_ovf, out_free;
    logic [BITWIDTH_SYS-1:0]  fifo_data;
    logic                     fifo_full, fifo_empty;
    logic [CNT_W-1:0]         fifo_count;

    skeleton_sync_fifo #(
        .WIDTH (BITWIDTH_SYS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .CLK_SYS   (CLK_SYS),
        .nRST      (nRST),
        .push      (push),
        .push_data (DUT_DATA),
        .pop       (pop),
        .pop_data  (fifo_data),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    // Host handshake: a word moves when M_VALID && M_READY at a clock edge.
    // The output register only reloads when empty or being drained, so the
    // word is held unchanged while stalled.
    assign out_free = !m_valid_q || M_READY;
    assign div_end  = (TRG_DIV == '0) ? '0 : TRG_DIV - DIV_WIDTH'(1);

    always_comb begin
        state_d   = state_q;
        div_d     = div_q;
        hidx_d    = hidx_q;
        push      = 1'b0;
        pop       = 1'b0;
        load      = 1'b0;
        load_data = '0;
        load_last = 1'b0;
        start_acc = 1'b0;
        set_ovf   = 1'b0;
        if (EN) begin
            case (state_q)
                IDLE, DONE: begin
                    if (START) begin
                        state_d   = WAIT;
                        div_d     = '0;
                        start_acc = 1'b1;
                    end
                end
                WAIT: begin
                    if (div_q == div_end) state_d = PULSE;
                    else                  div_d   = div_q + DIV_WIDTH'(1);
                end
                PULSE: begin
                    state_d = CAPT;
                    div_d   = '0;
                end
                CAPT: begin
                    if (div_q == DIV_WIDTH'(CAPT_DELAY - 1)) begin
                        push   = !fifo_full;
                        hidx_d = 1'b0;
                        // End-of-table wins over a simultaneous full FIFO.
                        if (DUT_RDY) begin
                            state_d = HEAD;
                        end else if (fifo_count == CNT_W'(FIFO_DEPTH - 1)) begin
                            state_d = HEAD;
                            set_ovf = 1'b1;
                        end else begin
                            state_d = WAIT;
                            div_d   = '0;
                        end
                    end else begin
                        div_d = div_q + DIV_WIDTH'(1);
                    end
                end
                HEAD: begin
                    if (out_free) begin
                        load      = 1'b1;
                        load_data = (hidx_q == 1'b0) ? BITWIDTH_SYS'(head_q[31:16])
                                                     : BITWIDTH_SYS'(head_q[15:0]);
                        hidx_d    = hidx_q + 1'b1;
                        if (hidx_q == 1'(HEAD_WORDS - 1)) begin
                            load_last = fifo_empty;
                            state_d   = DATA;
                        end
                    end
                end
                DATA: begin
                    if (m_valid_q && M_READY && m_last_q) begin
                        state_d = DONE;
                    end else if (out_free && !fifo_empty) begin
                        pop       = 1'b1;
                        load      = 1'b1;
                        load_data = fifo_data;
                        load_last = (fifo_count == CNT_W'(1));
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge CLK_SYS or negedge nRST) begin
        if (!nRST) begin
            state_q      <= IDLE;
            div_q        <= '0;
            hidx_q       <= 1'b0;
            head_q       <= '0;
            m_data_q     <= '0;
            m_valid_q    <= 1'b0;
            m_last_q     <= 1'b0;
            overflow_q   <= 1'b0;
            sample_cnt_q <= '0;
        end else begin
            state_q <= state_d;
            div_q   <= div_d;
            hidx_q  <= hidx_d;
            if (start_acc) begin
                head_q       <= 32'(DUT_HEAD);
                overflow_q   <= 1'b0;
                sample_cnt_q <= '0;
            end else begin
                if (set_ovf) overflow_q   <= 1'b1;
                if (push)    sample_cnt_q <= sample_cnt_q + CNT_W'(1);
            end
            if (load) begin
                m_data_q  <= load_data;
                m_valid_q <= 1'b1;
                m_last_q  <= load_last;
            end else if (m_valid_q && M_READY) begin
                m_valid_q <= 1'b0;
                m_last_q  <= 1'b0;
            end
        end
    end

    assign TRGG_START_CALC = EN && (state_q == PULSE);
    assign BUSY            = (state_q != IDLE) && (state_q != DONE);
    assign M_DATA          = m_data_q;
    assign M_VALID         = m_valid_q;
    assign M_LAST          = m_last_q;
    assign OVERFLOW        = overflow_q;
    assign SAMPLE_CNT      = sample_cnt_q;
    assign dbg_state       = state_q;

endmodule

// File: tb/tb_skeleton_wvf_capture.sv
// Bench for skeleton_wvf_capture: behavioural LUT model feeding a word
// scoreboard, with a separate monitor checking the host stream.
module tb_skeleton_wvf_capture;

    localparam int W     = 16;
    localparam int HW    = 32;
    localparam int DEPTH = 8;
    localparam int DW    = 16;
    localparam int CD    = 1;
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic             CLK_SYS = 1'b0;
    logic             nRST;
    logic             EN;
    logic             START;
    logic [DW-1:0]    TRG_DIV;
    logic             TRGG_START_CALC;
    logic [W-1:0]     DUT_DATA = '0;
    logic             DUT_RDY = 1'b0;
    logic [HW-7:0]    DUT_HEAD;
    logic [W-1:0]     M_DATA;
    logic             M_VALID;
    logic             M_READY;
    logic             M_LAST;
    logic             BUSY;
    logic             OVERFLOW;
    logic [CNT_W-1:0] SAMPLE_CNT;
    logic [2:0]       dbg_state;

    skeleton_wvf_capture #(
        .BITWIDTH_SYS  (W),
        .BITWIDTH_HEAD (HW),
        .FIFO_DEPTH    (DEPTH),
        .DIV_WIDTH     (DW),
        .CAPT_DELAY    (CD)
    ) dut (
        .CLK_SYS         (CLK_SYS),
        .nRST            (nRST),
        .EN              (EN),
        .START           (START),
        .TRG_DIV         (TRG_DIV),
        .TRGG_START_CALC (TRGG_START_CALC),
        .DUT_DATA        (DUT_DATA),
        .DUT_RDY         (DUT_RDY),
        .DUT_HEAD        (DUT_HEAD),
        .M_DATA          (M_DATA),
        .M_VALID         (M_VALID),
        .M_READY         (M_READY),
        .M_LAST          (M_LAST),
        .BUSY            (BUSY),
        .OVERFLOW        (OVERFLOW),
        .SAMPLE_CNT      (SAMPLE_CNT),
        .dbg_state       (dbg_state)
    );

    // ---------------- clock / cycle counter ----------------
    always #5 CLK_SYS = ~CLK_SYS;

    int cyc = 0;
    always @(posedge CLK_SYS) cyc <= cyc + 1;

    // ---------------- scoreboard state ----------------
    int           checks = 0;
    int           failures = 0;
    logic [W:0]   exp_q[$];      // {last, data}
    int           n_end = 0;     // sample index (1-based) that raises RDY; 0 = never
    int           k = 0;
    bit           pend = 1'b0;
    int           pulses = 0;
    int           prev_pulse = -1;
    int           exp_gap = 0;
    int           extra_gap = 0;
    int           exp_n = 0;
    bit           exp_ovf = 1'b0;
    int           words_run = 0;
    int           rdy_mode = 0;
    logic [W-1:0] smp;
    logic         smp_last;
    bit           have_hold = 1'b0;
    logic [W-1:0] hold_data;
    logic         hold_last;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic note_fail(input string name, input logic [31:0] act);
        checks++;
        failures++;
        $display("FAIL %s actual=%0h required=none", name, act);
    endtask

    // ---------------- LUT model ----------------
    // Data is valid only in the cycle CD after the trigger pulse; otherwise
    // the bus carries noise so a mistimed capture is visible.
    always @(negedge CLK_SYS) begin
        if (pend) begin
            smp      = W'($urandom);
            smp_last = ((n_end != 0) && (k + 1 == n_end)) || (k + 1 == DEPTH);
            DUT_DATA = smp;
            DUT_RDY  = (n_end != 0) && (k + 1 == n_end);
            exp_q.push_back({smp_last, smp});
            k++;
            pend = 1'b0;
        end else begin
            DUT_DATA = W'($urandom);
            DUT_RDY  = 1'($urandom_range(0, 1));
        end
        if (TRGG_START_CALC === 1'b1) begin
            pend = 1'b1;
            pulses++;
            if (prev_pulse >= 0)
                check("pulse_gap", 32'(cyc - prev_pulse), 32'(exp_gap + extra_gap));
            extra_gap  = 0;
            prev_pulse = cyc;
        end
    end

    // ---------------- monitor ----------------
    always @(negedge CLK_SYS) begin
        if (nRST !== 1'b1) begin
            have_hold = 1'b0;
        end else begin
            if (have_hold) begin
                check("stall_valid", 32'(M_VALID), 32'd1);
                check("stall_data", 32'(M_DATA), 32'(hold_data));
                check("stall_last", 32'(M_LAST), 32'(hold_last));
            end
            if (M_VALID === 1'b1 && M_READY === 1'b1) begin
                if (exp_q.size() == 0) begin
                    note_fail("extra_word", 32'(M_DATA));
                end else begin
                    logic [W:0] e;
                    e = exp_q.pop_front();
                    check("m_data", 32'(M_DATA), 32'(e[W-1:0]));
                    check("m_last", 32'(M_LAST), 32'(e[W]));
                end
                words_run++;
            end
            have_hold = (M_VALID === 1'b1) && (M_READY !== 1'b1);
            hold_data = M_DATA;
            hold_last = M_LAST;
        end
    end

    // ---------------- host ready driver ----------------
    initial begin
        M_READY = 1'b0;
        forever begin
            @(posedge CLK_SYS);
            #1;
            case (rdy_mode)
                0:       M_READY = 1'b1;
                1:       M_READY = !M_READY;
                default: M_READY = 1'($urandom_range(0, 1));
            endcase
        end
    end

    // ---------------- driver tasks ----------------
    task automatic check_zero(input string tag);
        check({tag, "_trg"},   32'(TRGG_START_CALC), 32'd0);
        check({tag, "_data"},  32'(M_DATA), 32'd0);
        check({tag, "_valid"}, 32'(M_VALID), 32'd0);
        check({tag, "_last"},  32'(M_LAST), 32'd0);
        check({tag, "_busy"},  32'(BUSY), 32'd0);
        check({tag, "_ovf"},   32'(OVERFLOW), 32'd0);
        check({tag, "_cnt"},   32'(SAMPLE_CNT), 32'd0);
    endtask

    task automatic start_run(input int n, input int div);
        logic [31:0] h;
        n_end      = n;
        k          = 0;
        pulses     = 0;
        prev_pulse = -1;
        extra_gap  = 0;
        words_run  = 0;
        exp_gap    = ((div == 0) ? 1 : div) + CD + 1;
        exp_n      = (n == 0 || n > DEPTH) ? DEPTH : n;
        exp_ovf    = (n == 0 || n > DEPTH);
        TRG_DIV    = DW'(div);
        DUT_HEAD   = (HW - 6)'($urandom);
        h          = 32'(DUT_HEAD);
        exp_q.push_back({1'b0, h[31:16]});
        exp_q.push_back({1'b0, h[15:0]});
        START = 1'b1;
        @(posedge CLK_SYS);
        #1;
        START    = 1'b0;
        DUT_HEAD = (HW - 6)'($urandom);
    endtask

    task automatic finish_run(input bit poke, input string tag);
        int t = 0;
        while (!(BUSY === 1'b0 && exp_q.size() == 0) && t < 3000) begin
            START = poke && (t % 9 == 4);
            @(posedge CLK_SYS);
            #1;
            t++;
        end
        START = 1'b0;
        if (t >= 3000) note_fail({tag, "_timeout_state"}, 32'(dbg_state));
        check({tag, "_sample_cnt"}, 32'(SAMPLE_CNT), 32'(exp_n));
        check({tag, "_overflow"},   32'(OVERFLOW), 32'(exp_ovf));
        check({tag, "_words"},      32'(words_run), 32'(exp_n + 2));
        check({tag, "_valid_end"},  32'(M_VALID), 32'd0);
        exp_q.delete();
        repeat (2) @(posedge CLK_SYS);
        #1;
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int t;
        nRST     = 1'b0;
        EN       = 1'b1;
        START    = 1'b0;
        TRG_DIV  = DW'(3);
        DUT_HEAD = '0;
        repeat (3) @(posedge CLK_SYS);
        #1;
        check_zero("reset");
        nRST = 1'b1;
        @(posedge CLK_SYS);
        #1;

        // 4-sample table, steady host
        rdy_mode = 0;
        start_run(4, 3);
        finish_run(1'b0, "basic");

        // table never ends: FIFO fills, overflow
        start_run(0, 2);
        finish_run(1'b0, "overflow");

        // alternating host ready
        rdy_mode = 1;
        start_run(5, 1);
        finish_run(1'b0, "toggle");

        // START pokes while busy are ignored
        rdy_mode = 0;
        start_run(4, 3);
        finish_run(1'b1, "start_busy");

        // EN low for 20 cycles inside WAIT
        start_run(6, 3);
        t = 0;
        while (pulses < 2 && t < 200) begin
            @(posedge CLK_SYS);
            #1;
            t++;
        end
        if (t >= 200) note_fail("en_pulse_timeout", 32'(pulses));
        repeat (2) @(posedge CLK_SYS);
        #1;
        extra_gap = 20;
        EN = 1'b0;
        repeat (20) begin
            @(posedge CLK_SYS);
            #1;
            check("en_stall_trg", 32'(TRGG_START_CALC), 32'd0);
        end
        EN = 1'b1;
        finish_run(1'b0, "en_stall");

        // reset while streaming samples
        rdy_mode = 1;
        start_run(0, 1);
        t = 0;
        while (words_run < 4 && t < 1000) begin
            @(posedge CLK_SYS);
            #1;
            t++;
        end
        if (t >= 1000) note_fail("abort_wait_timeout", 32'(words_run));
        nRST = 1'b0;
        @(negedge CLK_SYS);
        check_zero("abort");
        @(posedge CLK_SYS);
        #1;
        exp_q.delete();
        pend = 1'b0;
        @(posedge CLK_SYS);
        #1;
        nRST = 1'b1;
        @(posedge CLK_SYS);
        #1;
        rdy_mode = 0;
        start_run(3, 2);
        finish_run(1'b0, "after_abort");

        // randomized runs
        for (int r = 0; r < 6; r++) begin
            rdy_mode = 2;
            start_run($urandom_range(0, 10), $urandom_range(0, 4));
            finish_run(1'b0, "random");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog expired");
    end

endmodule
